// File: rtl/mcpu_pkg.sv
// mcpu_pkg
//   Shared definitions for the multi-cycle CPU memory responder:
//   FSM state encoding, the out-of-range read pattern, counter widths
//   and a small alignment helper.
package mcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;
  localparam int          CNT_W    = 16;
  localparam int          WCNT_W   = 4;

  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage

// File: rtl/mcpu_word_ram.sv
// mcpu_word_ram
//   DEPTH x DATA_W word storage for the memory responder.
//   Ports:
//     clk, reset          clock / async active-high reset (read register only)
//     ld_en/ld_idx/ld_data  preload write
//     wr_en/wr_idx/wr_data  CPU write; applied after the preload, so a CPU
//                           write to the same index on the same edge wins
//     rd_en/rd_idx/rd_data  synchronous read, output holds when rd_en low
//   Storage contents are not reset.
module mcpu_word_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/mcpu_mem_responder.sv
// mcpu_mem_responder
//   Memory responder for the multi-cycle CPU bus: on-chip data/instruction
//   RAM with programmable wait states, a one-cycle MIO_ready strobe, a sticky
//   range/alignment error flag and per-direction access counters.
//   Ports:
//     clk, reset                 clock / async active-high reset
//     CPU_MIO, mem_w             request strobe and direction (1 = write)
//     Addr_in, Data_wr           CPU byte address and write data
//     Data_rd                    read data, holds until the next read completes
//     MIO_ready                  one-cycle completion strobe
//     load_en/load_idx/load_data preload write port
//     err                        sticky out-of-range / misaligned flag
//     rd_count, wr_count         completed reads / writes, wrapping
//     trace_vld/trace_we/trace_addr  completion trace
//   Build option: define MEM_TRACE_EN to get the completion trace; without it
//   the trace outputs are tied low and no trace registers exist.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for CPU_MIO; request latched on acceptance
//   ST_WAIT | wait-state down-counter running, ACK when it reaches 0
//   ST_ACK  | MIO_ready high; CPU write committed at end of this cycle
module mcpu_mem_responder
  import mcpu_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                IDX_W     = $clog2(DEPTH),
  parameter int                WAIT_CYC  = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [ADDR_W-1:0] Addr_in,
  input  logic [DATA_W-1:0] Data_wr,
  output logic [DATA_W-1:0] Data_rd,
  output logic              MIO_ready,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic              err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              trace_vld,
  output logic              trace_we,
  output logic [ADDR_W-1:0] trace_addr
);

  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT_CYC > 0) ? WCNT_W'(WAIT_CYC - 1) : '0;
  localparam bit                NO_WAIT   = (WAIT_CYC == 0);

  state_t              state;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic                rd_oor_q;
  logic [DATA_W-1:0]   ram_rd_data;

  logic                idle;
  logic                accept;
  logic                enter_ack;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   sel_off;
  logic                sel_oor;
  logic                sel_bad;
  logic [IDX_W-1:0]    sel_idx;
  logic                ram_rd_en;
  logic                cpu_wr;

  assign idle   = (state == ST_IDLE);
  assign accept = idle & CPU_MIO & ~load_en;

  // With zero wait states ACK is entered straight from IDLE, so decode comes
  // from the live inputs in IDLE and from the latched request otherwise.
  assign sel_we   = idle ? mem_w   : lat_we;
  assign sel_addr = idle ? Addr_in : lat_addr;
  assign sel_off  = sel_addr - BASE_ADDR;
  assign sel_oor  = (sel_off >= SPAN);
  assign sel_idx  = sel_off[IDX_W+1:2];
  assign sel_bad  = sel_oor | misaligned(sel_addr[1:0]);

  assign enter_ack = (accept & NO_WAIT) | ((state == ST_WAIT) && (wait_cnt == '0));
  assign ram_rd_en = enter_ack & ~sel_we & ~sel_oor;
  assign cpu_wr    = (state == ST_ACK) & lat_we & ~sel_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      MIO_ready <= 1'b0;
      rd_oor_q  <= 1'b0;
      err       <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      MIO_ready <= enter_ack;
      if (enter_ack) begin
        err <= err | sel_bad;
        if (sel_we) begin
          wr_count <= wr_count + 1'b1;
        end else begin
          rd_count <= rd_count + 1'b1;
          rd_oor_q <= sel_oor;
        end
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we   <= mem_w;
            lat_addr <= Addr_in;
            lat_data <= Data_wr;
            wait_cnt <= WAIT_LOAD;
            state    <= NO_WAIT ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state    <= ST_ACK;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range reads leave the RAM read register untouched and select the
  // fixed pattern instead; both sources are registers, so Data_rd only moves
  // on a read completion.
  assign Data_rd = rd_oor_q ? DATA_W'(OOR_DATA) : ram_rd_data;

  mcpu_word_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .ld_en   (load_en),
    .ld_idx  (load_idx),
    .ld_data (load_data),
    .wr_en   (cpu_wr),
    .wr_idx  (sel_idx),
    .wr_data (lat_data),
    .rd_en   (ram_rd_en),
    .rd_idx  (sel_idx),
    .rd_data (ram_rd_data)
  );

`ifdef MEM_TRACE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_vld  <= 1'b0;
      trace_we   <= 1'b0;
      trace_addr <= '0;
    end else begin
      trace_vld <= enter_ack;
      if (enter_ack) begin
        trace_we   <= sel_we;
        trace_addr <= sel_addr;
      end
    end
  end
`else
  assign trace_vld  = 1'b0;
  assign trace_we   = 1'b0;
  assign trace_addr = '0;
`endif

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// Directed bench for mcpu_mem_responder: one instance with two wait states,
// one with none, sharing clock, reset, address/data and preload buses.
module tb_mcpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_mio = 1'b0;
  logic        cpu_mio0 = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_wr = '0;
  logic        load_en = 1'b0;
  logic [5:0]  load_idx = '0;
  logic [31:0] load_data = '0;

  logic [31:0] data_rd, data_rd0;
  logic        mio_ready, mio_ready0;
  logic        err, err0;
  logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
  logic        trace_vld, trace_we, trace_vld0, trace_we0;
  logic [31:0] trace_addr, trace_addr0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] s_data;
  logic        s_err, s_tv, s_twe, s_mio_after;
  logic [31:0] s_taddr;

  always #5 clk = ~clk;

  mcpu_mem_responder #(.WAIT_CYC(2)) u_dut (
    .clk(clk), .reset(reset), .CPU_MIO(cpu_mio), .mem_w(mem_w),
    .Addr_in(addr_in), .Data_wr(data_wr), .Data_rd(data_rd),
    .MIO_ready(mio_ready), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .err(err), .rd_count(rd_count),
    .wr_count(wr_count), .trace_vld(trace_vld), .trace_we(trace_we),
    .trace_addr(trace_addr)
  );

  mcpu_mem_responder #(.WAIT_CYC(0)) u_dut0 (
    .clk(clk), .reset(reset), .CPU_MIO(cpu_mio0), .mem_w(mem_w),
    .Addr_in(addr_in), .Data_wr(data_wr), .Data_rd(data_rd0),
    .MIO_ready(mio_ready0), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .err(err0), .rd_count(rd_count0),
    .wr_count(wr_count0), .trace_vld(trace_vld0), .trace_we(trace_we0),
    .trace_addr(trace_addr0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_idx = idx; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // ld_mode: 0 none, 1 preload on the request cycle (blocks acceptance),
  // 2 preload during the ACK cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ld_mode, input logic [5:0] lidx, input logic [31:0] ldata,
                        output int lat);
    lat = 0;
    @(negedge clk);
    mem_w = we; addr_in = addr; data_wr = wdata; cpu_mio = 1'b1;
    if (ld_mode == 1) begin
      load_en = 1'b1; load_idx = lidx; load_data = ldata;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      load_en = 1'b0;
      if (mio_ready) begin
        lat = k;
        s_data = data_rd; s_err = err;
        s_tv = trace_vld; s_twe = trace_we; s_taddr = trace_addr;
        break;
      end
    end
    cpu_mio = 1'b0;
    if (ld_mode == 2) begin
      load_en = 1'b1; load_idx = lidx; load_data = ldata;
    end
    @(posedge clk); #1;
    load_en = 1'b0;
    s_mio_after = mio_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int first;

    repeat (3) @(negedge clk);
    check_eq("rst_data_rd", data_rd, 32'h0);
    check_eq("rst_mio", {31'b0, mio_ready}, 32'h0);
    check_eq("rst_err", {31'b0, err}, 32'h0);
    check_eq("rst_rd_count", {16'b0, rd_count}, 32'h0);
    check_eq("rst_wr_count", {16'b0, wr_count}, 32'h0);
    check_eq("rst_trace", {trace_vld, trace_we, 30'b0} | trace_addr, 32'h0);
    reset = 1'b0;

    preload(6'd2, 32'h1234_5678);

    access(1'b0, 32'd8, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("rd8_latency", lat, 32'd3);
    check_eq("rd8_data", s_data, 32'h1234_5678);
    check_eq("rd8_strobe_one_cycle", {31'b0, s_mio_after}, 32'h0);

    access(1'b1, 32'd8, 32'hFFFF_0000, 0, 6'd0, 32'h0, lat);
    check_eq("wr8_latency", lat, 32'd3);
    check_eq("wr8_data_rd_hold", s_data, 32'h1234_5678);

    access(1'b0, 32'd8, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("rd8b_data", s_data, 32'hFFFF_0000);
    check_eq("rd8b_rd_count", {16'b0, rd_count}, 32'd2);
    check_eq("rd8b_wr_count", {16'b0, wr_count}, 32'd1);
    check_eq("rd8b_err", {31'b0, err}, 32'h0);

    access(1'b0, 32'd256, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("oor_data", s_data, 32'hDEAD_BEEF);
    check_eq("oor_err", {31'b0, s_err}, 32'h1);
    check_eq("oor_rd_count", {16'b0, rd_count}, 32'd3);

    access(1'b1, 32'd6, 32'hA5A5_0001, 0, 6'd0, 32'h0, lat);
    check_eq("mis_wr_hold", s_data, 32'hDEAD_BEEF);
    check_eq("mis_wr_err", {31'b0, s_err}, 32'h1);

    access(1'b0, 32'd4, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("rd4_data", s_data, 32'hA5A5_0001);
    check_eq("rd4_err_sticky", {31'b0, err}, 32'h1);
`ifdef MEM_TRACE_EN
    check_eq("trace_vld", {31'b0, s_tv}, 32'h1);
    check_eq("trace_we", {31'b0, s_twe}, 32'h0);
    check_eq("trace_addr", s_taddr, 32'd4);
`else
    check_eq("trace_vld_tied", {31'b0, s_tv}, 32'h0);
    check_eq("trace_we_tied", {31'b0, s_twe}, 32'h0);
    check_eq("trace_addr_tied", s_taddr, 32'h0);
`endif

    access(1'b1, 32'd20, 32'h1111_1111, 2, 6'd5, 32'h2222_2222, lat);
    access(1'b0, 32'd20, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("cpu_wins_load", s_data, 32'h1111_1111);

    access(1'b0, 32'd8, 32'h0, 1, 6'd7, 32'h7777_7777, lat);
    check_eq("load_blocks_latency", lat, 32'd4);
    check_eq("load_blocks_data", s_data, 32'hFFFF_0000);

    access(1'b0, 32'd28, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("rd28_loaded", s_data, 32'h7777_7777);
    check_eq("cnt_rd_7", {16'b0, rd_count}, 32'd7);
    check_eq("cnt_wr_3", {16'b0, wr_count}, 32'd3);

    preload(6'd3, 32'h3333_0003);
    @(negedge clk);
    mem_w = 1'b1; addr_in = 32'd12; data_wr = 32'h9999_9999; cpu_mio = 1'b1;
    @(posedge clk); #1;
    cpu_mio = 1'b0;
    seen = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (mio_ready) seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (mio_ready) seen++;
    end
    check_eq("abort_no_ready", seen, 32'd0);
    check_eq("abort_rd_count", {16'b0, rd_count}, 32'd0);
    check_eq("abort_wr_count", {16'b0, wr_count}, 32'd0);
    check_eq("abort_err", {31'b0, err}, 32'h0);
    check_eq("abort_data_rd", data_rd, 32'h0);
    access(1'b0, 32'd12, 32'h0, 0, 6'd0, 32'h0, lat);
    check_eq("abort_word3_kept", s_data, 32'h3333_0003);
    check_eq("abort_rd_latency", lat, 32'd3);

    seen = 0;
    first = 0;
    @(negedge clk);
    mem_w = 1'b0; addr_in = 32'd8; cpu_mio0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (mio_ready0) begin
        seen++;
        if (first == 0) first = k;
      end
    end
    cpu_mio0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("w0_completions", seen, 32'd5);
    check_eq("w0_first_latency", first, 32'd1);
    check_eq("w0_rd_count", {16'b0, rd_count0}, 32'd5);
    check_eq("w0_data", data_rd0, 32'h1234_5678);
    check_eq("w0_err", {31'b0, err0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
